// File: rtl/jk_ctrl_pkg.sv
// Shared encodings for the JK counter sequencer: command op codes and FSM states.
package jk_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_RUN_UP   = 2'b00,
    OP_RUN_DOWN = 2'b01,
    OP_LOAD     = 2'b10,
    OP_STOP     = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_CLR  = 2'b00,
    ST_IDLE = 2'b01,
    ST_LOAD = 2'b10,
    ST_RUN  = 2'b11
  } state_e;

endpackage

// File: rtl/jk_bank.sv
// Bank of WIDTH posedge JK flip-flops; the controller steers it through J/K only.
module jk_bank #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q
);

  // NOTE: the bank has no reset pin; it is cleared by the controller's CLR state driving K=1.
  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      case ({j[i], k[i]})
        2'b01:   q[i] <= 1'b0;
        2'b10:   q[i] <= 1'b1;
        2'b11:   q[i] <= ~q[i];
        default: q[i] <= q[i];
      endcase
    end
  end

endmodule

// File: rtl/jk_count_ctrl.sv
// Command FSM that sequences a JK flop bank as a clearable, loadable up/down
// modulo counter with a run-time wrap limit and a registered terminal-count pulse.
module jk_count_ctrl
  import jk_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             cl,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] q_in,
  output logic [WIDTH-1:0] j_out,
  output logic [WIDTH-1:0] k_out,
  output logic             busy,
  output logic             tc
);

  state_e           state;
  logic             dir_down;
  logic [WIDTH-1:0] ld_val;
  logic             wrap;
  logic [WIDTH-1:0] t_mask;
  logic             accept;
  op_e              op;

  assign op     = op_e'(cmd_op);
  assign accept = cmd_valid & cmd_ready;
  assign busy   = (state != ST_IDLE);

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    j_out     = '0;
    k_out     = '0;
    cmd_ready = 1'b0;
    wrap      = 1'b0;
    t_mask    = '0;
    case (state)
      ST_CLR: k_out = '1;
      ST_IDLE: cmd_ready = 1'b1;
      ST_LOAD: begin
        j_out = ld_val;
        k_out = ~ld_val;
      end
      ST_RUN: begin
        cmd_ready = 1'b1;
        if (dir_down) begin
          if (q_in == '0) begin
            wrap  = 1'b1;
            j_out = limit;
            k_out = ~limit;
          end else begin
            t_mask = q_in ^ (q_in - 1'b1);
            j_out  = t_mask;
            k_out  = t_mask;
          end
        end else begin
          // Anything at or above the limit wraps straight to zero.
          if (q_in >= limit) begin
            wrap  = 1'b1;
            k_out = '1;
          end else begin
            t_mask = q_in ^ (q_in + 1'b1);
            j_out  = t_mask;
            k_out  = t_mask;
          end
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (cl) begin
      state    <= ST_CLR;
      dir_down <= 1'b0;
      ld_val   <= '0;
      tc       <= 1'b0;
    end else begin
      tc <= wrap;
      case (state)
        ST_CLR, ST_LOAD: state <= ST_IDLE;
        ST_IDLE, ST_RUN: begin
          if (accept) begin
            case (op)
              OP_RUN_UP: begin
                state    <= ST_RUN;
                dir_down <= 1'b0;
              end
              OP_RUN_DOWN: begin
                state    <= ST_RUN;
                dir_down <= 1'b1;
              end
              OP_LOAD: begin
                state  <= ST_LOAD;
                ld_val <= cmd_data;
              end
              default: state <= ST_IDLE;
            endcase
          end
        end
        default: state <= ST_CLR;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_count_ctrl.sv
// Randomised and directed bench for jk_count_ctrl driving a jk_bank, checked
// against an arithmetic model of the counter value, mode and terminal count.
module tb_jk_count_ctrl;
  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             cl = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b11;
  logic [WIDTH-1:0] cmd_data = '0;
  logic [WIDTH-1:0] limit = '0;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] j_out, k_out;
  logic             busy, tc;

  jk_count_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .cl(cl), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .limit(limit), .q_in(q),
    .j_out(j_out), .k_out(k_out), .busy(busy), .tc(tc)
  );

  jk_bank #(.WIDTH(WIDTH)) bank (.clk(clk), .j(j_out), .k(k_out), .q(q));

  always #5 clk = ~clk;

  typedef enum int {M_CLR, M_IDLE, M_LOAD, M_RUN} mode_t;
  mode_t m_mode = M_CLR;
  int    m_q = 0, m_ld = 0, m_tc = 0;
  bit    m_up = 1'b1;
  int    checks = 0, failures = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One clock: compare outputs at the negedge, then advance the model across the posedge.
  task automatic cycle();
    int    lim, qn, tcn, ldn;
    bit    upn, acc;
    mode_t mn;
    @(negedge clk);
    check("q", 32'(q), 32'(m_q));
    check("busy", 32'(busy), 32'(m_mode != M_IDLE));
    check("ready", 32'(cmd_ready), 32'(m_mode == M_IDLE || m_mode == M_RUN));
    check("tc", 32'(tc), 32'(m_tc));
    lim = int'(limit);
    qn  = m_q;
    tcn = 0;
    upn = m_up;
    ldn = m_ld;
    mn  = m_mode;
    case (m_mode)
      M_CLR:  qn = 0;
      M_LOAD: qn = m_ld;
      M_RUN: begin
        if (m_up) begin
          tcn = (m_q >= lim) ? 1 : 0;
          qn  = (m_q >= lim) ? 0 : (m_q + 1) % 16;
        end else begin
          tcn = (m_q == 0) ? 1 : 0;
          qn  = (m_q == 0) ? lim : m_q - 1;
        end
      end
      default: ;
    endcase
    acc = cmd_valid && (m_mode == M_IDLE || m_mode == M_RUN);
    if (m_mode == M_CLR || m_mode == M_LOAD) mn = M_IDLE;
    else if (acc) begin
      case (cmd_op)
        2'b00: begin mn = M_RUN; upn = 1'b1; end
        2'b01: begin mn = M_RUN; upn = 1'b0; end
        2'b10: begin mn = M_LOAD; ldn = int'(cmd_data); end
        default: mn = M_IDLE;
      endcase
    end
    if (cl) begin
      mn = M_CLR; upn = 1'b1; ldn = 0; tcn = 0;
    end
    @(posedge clk);
    #1;
    m_q = qn; m_tc = tcn; m_up = upn; m_ld = ldn; m_mode = mn;
  endtask

  task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cycle();
    cmd_valid = 1'b0;
  endtask

  task automatic run_until(input int target);
    for (int n = 0; n < 40 && int'(q) != target; n++) cycle();
    check("reach_q", 32'(q), 32'(target));
  endtask

  initial begin
    // 1: reset held two edges clears the bank; model takes over after release
    repeat (2) @(posedge clk);
    #1;
    cl = 1'b0;
    m_mode = M_CLR; m_q = 0; m_tc = 0; m_up = 1'b1; m_ld = 0;
    repeat (2) cycle();
    check("idle_busy", 32'(busy), 32'(0));
    check("idle_ready", 32'(cmd_ready), 32'(1));

    // 2: count up to 9 and wrap
    limit = 4'd9;
    send(2'b00, '0);
    repeat (12) cycle();

    // 3: load 5 and count down with limit 7
    send(2'b11, '0);
    send(2'b10, 4'd5);
    repeat (2) cycle();
    check("load5", 32'(q), 32'(5));
    limit = 4'd7;
    send(2'b01, '0);
    repeat (9) cycle();

    // 4: LOAD issued mid-run at q=3
    limit = 4'd9;
    send(2'b00, '0);
    run_until(3);
    send(2'b10, 4'd12);
    repeat (4) cycle();
    check("held12", 32'(q), 32'(12));

    // 5: reset mid-run with a command pending
    send(2'b00, '0);
    run_until(6);
    cl = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b10; cmd_data = 4'd9;
    cycle();
    cl = 1'b0; cmd_valid = 1'b0;
    repeat (3) cycle();
    check("cl_q0", 32'(q), 32'(0));

    // 6: limit 0 holds at zero with tc every cycle, then STOP
    limit = '0;
    send(2'b00, '0);
    repeat (4) cycle();
    check("lim0_tc", 32'(tc), 32'(1));
    send(2'b11, '0);
    repeat (3) cycle();

    // random traffic, including q above limit and occasional reset
    for (int n = 0; n < 400; n++) begin
      cl        = ($urandom_range(0, 49) == 0);
      cmd_valid = $urandom_range(0, 2) == 0;
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_data  = 4'($urandom);
      if ($urandom_range(0, 7) == 0) limit = 4'($urandom);
      cycle();
    end
    cl = 1'b0;
    cmd_valid = 1'b0;
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
